// File: rtl/soc_bus_pkg.sv
// Shared definitions for SoC bus masters: FSM states, owner encoding and
// default bus widths.
package soc_bus_pkg;

  localparam int DEFAULT_AW = 32;
  localparam int DEFAULT_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } busState_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Loadable up-counter with clear and enable. The expired flag rises while the
// count sits one below the limit, so an enabled cycle there ends the wait.
module bus_timeout_ctr #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] loadVal,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic          expired
);

  logic [CW-1:0] countReg;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      countReg <= '0;
    end else if (load) begin
      countReg <= loadVal;
    end else if (en) begin
      countReg <= countReg + CW'(1);
    end
  end

  assign expired = (countReg == limit - CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester memory bus arbiter for the 5-stage core: serialises fetch and
// data accesses onto one bus, with a data-streak cap and slave timeout.
module mem_port_arbiter
  import soc_bus_pkg::*;
#(
  parameter int AW          = DEFAULT_AW,
  parameter int DW          = DEFAULT_DW,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ack,
  output logic            bus_valid,
  output logic            bus_we,
  output logic [DW/8-1:0] bus_be,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  input  logic            bus_ready,
  input  logic [DW-1:0]   bus_rdata,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            bus_err
);

  localparam int STREAK_W = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);

  busState_t         stateReg, stateNext;
  logic              ownerReg;
  logic [STREAK_W-1:0] streakReg;
  logic              busValidReg, busWeReg;
  logic [DW/8-1:0]   busBeReg;
  logic [AW-1:0]     busAddrReg;
  logic [DW-1:0]     busWdataReg, ifRdataReg, dRdataReg, respData;
  logic              ifAckReg, dAckReg, busErrReg;

  logic startTxn, grantD, doneOk, doneTo, ctrEn, toExpired, streakAtMax;

  assign streakAtMax = (streakReg == STREAK_W'(MAX_DSTREAK));
  assign ctrEn       = (stateReg == BUSY) && !bus_ready;

  bus_timeout_ctr #(
    .CW(16)
  ) timeoutCtr (
    .clk     (clk),
    .reset   (reset),
    .clr     (startTxn),
    .load    (1'b0),
    .loadVal (16'd0),
    .en      (ctrEn),
    .limit   (16'(TIMEOUT)),
    .expired (toExpired)
  );

  always_comb begin
    stateNext = stateReg;
    startTxn  = 1'b0;
    grantD    = 1'b0;
    doneOk    = 1'b0;
    doneTo    = 1'b0;
    case (stateReg)
      IDLE: begin
        if (if_req || d_req) begin
          startTxn  = 1'b1;
          // Data normally wins; a waiting fetch gets through once the cap is hit.
          grantD    = d_req && !(if_req && streakAtMax);
          stateNext = BUSY;
        end
      end
      BUSY: begin
        if (bus_ready) begin
          doneOk    = 1'b1;
          stateNext = RESP;
        end else if (toExpired) begin
          doneTo    = 1'b1;
          stateNext = RESP;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign respData = doneTo ? '0 : bus_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg    <= IDLE;
      ownerReg    <= OWN_IF;
      streakReg   <= '0;
      busValidReg <= 1'b0;
      busWeReg    <= 1'b0;
      busBeReg    <= '0;
      busAddrReg  <= '0;
      busWdataReg <= '0;
      ifRdataReg  <= '0;
      dRdataReg   <= '0;
      ifAckReg    <= 1'b0;
      dAckReg     <= 1'b0;
      busErrReg   <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      ifAckReg  <= 1'b0;
      dAckReg   <= 1'b0;
      busErrReg <= 1'b0;
      if (startTxn) begin
        busValidReg <= 1'b1;
        ownerReg    <= grantD ? OWN_D : OWN_IF;
        if (grantD) begin
          busWeReg    <= d_we;
          busBeReg    <= d_be;
          busAddrReg  <= d_addr;
          busWdataReg <= d_wdata;
          streakReg   <= if_req ? streakReg + STREAK_W'(1) : '0;
        end else begin
          busWeReg    <= 1'b0;
          busBeReg    <= '1;
          busAddrReg  <= if_addr;
          busWdataReg <= '0;
          streakReg   <= '0;
        end
      end
      if (doneOk || doneTo) begin
        busValidReg <= 1'b0;
        busErrReg   <= doneTo;
        if (ownerReg == OWN_D) begin
          dRdataReg <= respData;
          dAckReg   <= 1'b1;
        end else begin
          ifRdataReg <= respData;
          ifAckReg   <= 1'b1;
        end
      end
    end
  end

  assign bus_valid = busValidReg;
  assign bus_we    = busWeReg;
  assign bus_be    = busBeReg;
  assign bus_addr  = busAddrReg;
  assign bus_wdata = busWdataReg;
  assign if_rdata  = ifRdataReg;
  assign d_rdata   = dRdataReg;
  assign if_ack    = ifAckReg;
  assign d_ack     = dAckReg;
  assign bus_err   = busErrReg;
  assign stall_if  = if_req & ~ifAckReg;
  assign stall_mem = d_req & ~dAckReg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench: a transaction-level timing model predicts each
// grant, its bus fields and its ack cycle; a monitor compares every cycle.
module tb_mem_port_arbiter;
  import soc_bus_pkg::*;

  localparam int AW = 32, DW = 32, MAXS = 4, TMO = 8, NCYC = 1600;

  logic clk, reset;
  logic if_req, if_ack, d_req, d_we, d_ack;
  logic [AW-1:0] if_addr, d_addr, bus_addr;
  logic [DW-1:0] if_rdata, d_wdata, d_rdata, bus_wdata, bus_rdata;
  logic [3:0] d_be, bus_be;
  logic bus_valid, bus_we, bus_ready, stall_if, stall_mem, bus_err;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DSTREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        owner;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          a;   // edge at which the grant is sampled
    int          e;   // edge after which the ack is visible
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, got, exp);
  endtask

  // Stimulus, slave and reference model
  initial begin
    int k, nextArb, curA, curE, streak, w, phase, pIf, pD;
    bit ifPend, dPend, winnerD, curActive, curTo, forcedRst, doRst;
    logic [31:0] ifA, dA, dW, slaveData;
    logic dWe;
    logic [3:0] dBe;
    exp_t ent;
    ifPend = 0; dPend = 0; curActive = 0; curTo = 0; forcedRst = 0;
    streak = 0; nextArb = 4; curA = 0; curE = 0; winnerD = 0;
    ifA = 0; dA = 0; dW = 0; dWe = 0; dBe = 0; slaveData = 0;
    reset = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0;
    d_addr = 0; d_wdata = 0; bus_ready = 0; bus_rdata = 0;
    for (int n = 0; n < NCYC; n++) begin
      @(negedge clk);
      k = cyc + 1;
      if (k <= 3) begin
        reset = 1'b1;
        continue;
      end
      reset = 1'b0;
      phase = (n < 600) ? 0 : (n < 850) ? 1 : 2;
      pIf = (phase == 1) ? 100 : 35;
      pD  = (phase == 1) ? 100 : 45;
      if (curActive && k == curE + 2) begin
        curActive = 0;
        if (winnerD) dPend = 0; else ifPend = 0;
      end
      // Occasional reset while the slave is stalling mid-transaction
      doRst = 0;
      if (phase != 1 && curActive && k > curA && k < curE)
        doRst = (phase == 2 && !forcedRst) || ($urandom_range(0, 19) == 0);
      if (doRst) begin
        forcedRst = 1;
        reset = 1'b1; bus_ready = 1'b0; if_req = 1'b0; d_req = 1'b0;
        sbq.delete();
        ifPend = 0; dPend = 0; curActive = 0; streak = 0; nextArb = k + 1;
        continue;
      end
      if (!ifPend && $urandom_range(1, 100) <= pIf) begin
        ifPend = 1; ifA = $urandom;
      end
      if (!dPend && $urandom_range(1, 100) <= pD) begin
        dPend = 1; dA = $urandom; dW = $urandom;
        dWe = 1'($urandom_range(0, 1)); dBe = 4'($urandom_range(0, 15));
      end
      if_req  = ifPend;
      if_addr = ifPend ? ifA : $urandom;
      d_req   = dPend;
      d_addr  = dPend ? dA : $urandom;
      d_wdata = dPend ? dW : $urandom;
      d_we    = dPend ? dWe : 1'($urandom_range(0, 1));
      d_be    = dPend ? dBe : 4'($urandom_range(0, 15));
      if (k == nextArb) begin
        if (ifPend || dPend) begin
          winnerD = dPend && !(ifPend && streak == MAXS);
          if (winnerD) streak = ifPend ? streak + 1 : 0;
          else streak = 0;
          curTo = (phase != 1) && ($urandom_range(0, 12) == 0);
          if (phase == 1) w = 0;
          else begin
            w = $urandom_range(0, 9);
            w = (w < 5) ? 0 : (w < 9) ? $urandom_range(1, 3) : TMO - 1;
          end
          curA = k;
          curE = curTo ? k + TMO : k + 1 + w;
          slaveData = $urandom;
          ent.owner = winnerD ? OWN_D : OWN_IF;
          ent.addr  = winnerD ? dA : ifA;
          ent.we    = winnerD ? dWe : 1'b0;
          ent.be    = winnerD ? dBe : 4'hF;
          ent.wdata = winnerD ? dW : 32'h0;
          ent.rdata = curTo ? 32'h0 : slaveData;
          ent.err   = curTo;
          ent.a     = curA;
          ent.e     = curE;
          sbq.push_back(ent);
          curActive = 1;
          nextArb = curE + 2;
        end else begin
          nextArb = k + 1;
        end
      end
      if (curActive && k > curA && k <= curE) begin
        bus_ready = (k == curE) && !curTo;
        bus_rdata = (k == curE) ? slaveData : $urandom;
      end else begin
        bus_ready = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Monitor: pops the scoreboard when an ack is presented or falls due
  initial begin
    exp_t h;
    logic [31:0] lastIf, lastD, got;
    bit expAckIf, expAckD, expValid;
    lastIf = 0; lastD = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        chk("reset_state", 80'({bus_valid, bus_we, bus_be, bus_addr, bus_wdata, if_ack, d_ack, bus_err}), 80'(0));
        chk("reset_rdata", 80'({if_rdata, d_rdata}), 80'(0));
        lastIf = 0; lastD = 0;
      end else begin
        expAckIf = 0; expAckD = 0;
        if (if_ack || d_ack || (sbq.size() > 0 && sbq[0].e <= cyc)) begin
          if (sbq.size() == 0) begin
            chk("unexpected_ack", 80'({if_ack, d_ack}), 80'(0));
          end else begin
            h = sbq.pop_front();
            expAckIf = (h.e == cyc) && (h.owner == OWN_IF);
            expAckD  = (h.e == cyc) && (h.owner == OWN_D);
            got = if_ack ? if_rdata : d_rdata;
            chk("ack", 80'({32'(cyc), if_ack, d_ack, got, bus_err}),
                80'({32'(h.e), h.owner == OWN_IF, h.owner == OWN_D, h.rdata, h.err}));
            if (h.owner == OWN_IF) lastIf = h.rdata; else lastD = h.rdata;
          end
        end else begin
          chk("bus_err_idle", 80'(bus_err), 80'(0));
        end
        expValid = (sbq.size() > 0) && (cyc >= sbq[0].a) && (cyc < sbq[0].e);
        chk("bus_valid", 80'(bus_valid), 80'(expValid));
        if (expValid && bus_valid)
          chk("bus_fields", 80'({bus_we, bus_be, bus_addr, bus_we ? bus_wdata : 32'h0}),
              80'({sbq[0].we, sbq[0].be, sbq[0].addr, sbq[0].we ? sbq[0].wdata : 32'h0}));
        chk("rdata_hold", 80'({if_rdata, d_rdata}), 80'({lastIf, lastD}));
        chk("stall", 80'({stall_if, stall_mem}), 80'({if_req & ~expAckIf, d_req & ~expAckD}));
      end
    end
  end

endmodule
